// File: rtl/hazard_controller.sv
// Hazard and sequencing controller for the 5-stage F/D/E/M/W pipeline.
// Produces stall/flush enables for the four pipe registers and forwarding
// selects for the execute-stage operand muxes. A two-state FSM with a
// down-counter holds a multi-cycle mul/div op in E; a data-memory wait
// freezes the whole pipe and takes priority over everything else.
module hazard_controller #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MDU_LATENCY    = 4,
    parameter int CNT_WIDTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
    input  logic [REG_ADDR_WIDTH-1:0] RdE,
    input  logic [REG_ADDR_WIDTH-1:0] RdM,
    input  logic [REG_ADDR_WIDTH-1:0] RdW,
    input  logic                      RegWriteM,
    input  logic                      RegWriteW,
    input  logic                      LoadE,
    input  logic                      PCSrcE,
    input  logic                      MulDivE,
    input  logic                      MemReqM,
    input  logic                      MemReadyM,
    output logic [1:0]                ForwardAE,
    output logic [1:0]                ForwardBE,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      StallE,
    output logic                      StallM,
    output logic                      FlushD,
    output logic                      FlushE,
    output logic                      FlushM,
    output logic                      FlushW,
    output logic                      MduBusy
);

    // Operand select encodings
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = {REG_ADDR_WIDTH{1'b0}};

    // A single-cycle MDU configuration never needs to hold E.
    localparam logic MDU_MULTI = (MDU_LATENCY >= 2) ? 1'b1 : 1'b0;

    // The entry cycle is spent in RUN and the release cycle at cnt==0 in MDU,
    // so the counter is loaded with LATENCY-2 remaining stall cycles.
    localparam int                   CNT_LOAD_INT = (MDU_LATENCY >= 2) ? (MDU_LATENCY - 2) : 0;
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD     = CNT_WIDTH'(CNT_LOAD_INT);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO     = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

    typedef enum logic [0:0] {
        RUN = 1'b0,
        MDU = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [CNT_WIDTH-1:0] cnt_next_s;

    logic       memwait_s;
    logic       load_use_s;
    logic [1:0] fwd_a_s;
    logic [1:0] fwd_b_s;
    logic       stall_f_s;
    logic       stall_d_s;
    logic       stall_e_s;
    logic       stall_m_s;
    logic       flush_d_s;
    logic       flush_e_s;
    logic       flush_m_s;
    logic       flush_w_s;
    logic       mdu_busy_s;

    // Forwarding priority: the younger producer in M beats the one in W; x0
    // is never forwarded because it is hard-wired to zero.
    function automatic logic [1:0] fwd_select(
        input logic [REG_ADDR_WIDTH-1:0] rs,
        input logic [REG_ADDR_WIDTH-1:0] rd_m,
        input logic [REG_ADDR_WIDTH-1:0] rd_w,
        input logic                      wr_m,
        input logic                      wr_w
    );
        logic [1:0] sel;
        if (wr_m && (rd_m != REG_ZERO) && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (wr_w && (rd_w != REG_ZERO) && (rd_w == rs)) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    // Hazard qualifiers shared by the sequencing logic
    always_comb begin
        memwait_s  = MemReqM && !MemReadyM;
        load_use_s = LoadE && (RdE != REG_ZERO) && ((RdE == Rs1D) || (RdE == Rs2D));
        fwd_a_s    = fwd_select(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
        fwd_b_s    = fwd_select(Rs2E, RdM, RdW, RegWriteM, RegWriteW);
    end

    // Next-state and raw stall/flush decode, memory wait first
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        stall_f_s    = 1'b0;
        stall_d_s    = 1'b0;
        stall_e_s    = 1'b0;
        stall_m_s    = 1'b0;
        flush_d_s    = 1'b0;
        flush_e_s    = 1'b0;
        flush_m_s    = 1'b0;
        flush_w_s    = 1'b0;
        mdu_busy_s   = 1'b0;

        if (memwait_s) begin
            // Freeze every stage register and drain W with a bubble; the MDU
            // sequencer and counter hold so the op resumes where it left off.
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            stall_e_s = 1'b1;
            stall_m_s = 1'b1;
            flush_w_s = 1'b1;
        end else begin
            case (state_r)
                RUN: begin
                    if (MulDivE && MDU_MULTI) begin
                        stall_f_s    = 1'b1;
                        stall_d_s    = 1'b1;
                        stall_e_s    = 1'b1;
                        flush_m_s    = 1'b1;
                        mdu_busy_s   = 1'b1;
                        state_next_s = MDU;
                        cnt_next_s   = CNT_LOAD;
                    end else if (PCSrcE) begin
                        // Taken branch squashes the wrong-path ops in D and E,
                        // which also cancels any load-use stall they caused.
                        flush_d_s = 1'b1;
                        flush_e_s = 1'b1;
                    end else if (load_use_s) begin
                        stall_f_s = 1'b1;
                        stall_d_s = 1'b1;
                        flush_e_s = 1'b1;
                    end else begin
                        state_next_s = RUN;
                    end
                end
                MDU: begin
                    if (cnt_r != CNT_ZERO) begin
                        stall_f_s  = 1'b1;
                        stall_d_s  = 1'b1;
                        stall_e_s  = 1'b1;
                        flush_m_s  = 1'b1;
                        mdu_busy_s = 1'b1;
                        cnt_next_s = cnt_r - CNT_ONE;
                    end else begin
                        // Final cycle of the op: pipe advances at this edge.
                        state_next_s = RUN;
                    end
                end
                default: begin
                    state_next_s = RUN;
                    cnt_next_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // Sequencer state and MDU down-counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RUN;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Output stage: reset forces every control quiet without waiting for a clock
    always_comb begin
        if (rst) begin
            ForwardAE = FWD_RF;
            ForwardBE = FWD_RF;
            StallF    = 1'b0;
            StallD    = 1'b0;
            StallE    = 1'b0;
            StallM    = 1'b0;
            FlushD    = 1'b0;
            FlushE    = 1'b0;
            FlushM    = 1'b0;
            FlushW    = 1'b0;
            MduBusy   = 1'b0;
        end else begin
            ForwardAE = fwd_a_s;
            ForwardBE = fwd_b_s;
            StallF    = stall_f_s;
            StallD    = stall_d_s;
            StallE    = stall_e_s;
            StallM    = stall_m_s;
            FlushD    = flush_d_s;
            FlushE    = flush_e_s;
            FlushM    = flush_m_s;
            FlushW    = flush_w_s;
            MduBusy   = mdu_busy_s;
        end
    end

endmodule
